// File: rtl/par_gen_fifo.sv
// rtl/par_gen_fifo.sv - even-parity generating FIFO; PAR_FIFO_ERR_INJ_EN adds the err_inj port
module par_gen_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [WIDTH-1:0]       wr_data,
`ifdef PAR_FIFO_ERR_INJ_EN
    input  logic                   err_inj,
`endif
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       data,
    output logic                   parity,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            push, pop, par_bit;

    assign wr_ready = (level_q != FULL_LVL);
    assign rd_valid = (level_q != '0);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign level    = level_q;

`ifdef PAR_FIFO_ERR_INJ_EN
    assign par_bit = (^wr_data) ^ err_inj;
`else
    assign par_bit = ^wr_data;
`endif

    // Head entry is always driven from storage, so the parity pair stays consistent even when empty.
    assign {parity, data} = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {par_bit, wr_data};
        end
    end
endmodule
